// File: rtl/vae_fixed_pkg.sv
// Shared Q8.8 fixed-point constants and helpers for the VAE latent path.
// Also holds the Galois LFSR tap mask used by vae_lfsr16.
package vae_fixed_pkg;

    localparam int unsigned Q88_W    = 16;
    localparam int unsigned Q88_FRAC = 8;
    localparam int unsigned PROD_W   = 2 * Q88_W;
    localparam int unsigned SUM_W    = Q88_W + 1;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned EPS_BITS = 10;

    localparam logic signed [Q88_W-1:0] Q88_MAX   = 16'sh7FFF;
    localparam logic signed [Q88_W-1:0] Q88_MIN   = 16'sh8000;
    localparam logic [LFSR_W-1:0]       LFSR_TAPS = 16'hB400;

    // Clamp a wide signed value into the Q8.8 range.
    function automatic logic signed [Q88_W-1:0] sat_q88(input logic signed [PROD_W-1:0] x);
        if (x > PROD_W'(Q88_MAX)) return Q88_MAX;
        if (x < PROD_W'(Q88_MIN)) return Q88_MIN;
        return Q88_W'(x);
    endfunction

    // Q16.16 -> Q8.8 with round-half-up; result still needs saturation.
    function automatic logic signed [PROD_W-1:0] round_q88(input logic signed [PROD_W-1:0] p);
        return (p + 32'sh80) >>> Q88_FRAC;
    endfunction

endpackage

// File: rtl/vae_reparam_sampler_if.sv
// Stream interface of the reparameterisation sampler: latent input and z output.
// eps_in exists only when VAE_SAMPLER_LFSR_EN is undefined.
interface vae_reparam_sampler_if;
    import vae_fixed_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [Q88_W-1:0] mu;
    logic signed [Q88_W-1:0] alfa;
`ifndef VAE_SAMPLER_LFSR_EN
    logic signed [Q88_W-1:0] eps_in;
`endif
    logic                    out_valid;
    logic                    out_ready;
    logic signed [Q88_W-1:0] z;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;

`ifdef VAE_SAMPLER_LFSR_EN
    modport master (output in_valid, mu, alfa, out_ready,
                    input  in_ready, out_valid, z, out_idx, out_last);
    modport slave  (input  in_valid, mu, alfa, out_ready,
                    output in_ready, out_valid, z, out_idx, out_last);
`else
    modport master (output in_valid, mu, alfa, eps_in, out_ready,
                    input  in_ready, out_valid, z, out_idx, out_last);
    modport slave  (input  in_valid, mu, alfa, eps_in, out_ready,
                    output in_ready, out_valid, z, out_idx, out_last);
`endif

endinterface

// File: rtl/vae_lfsr16.sv
// 16-bit Galois LFSR noise source; load restores SEED, advance steps once.
module vae_lfsr16
    import vae_fixed_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    // Load wins over advance so the element accepted alongside a load still sees the old state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (advance) begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/vae_reparam_sampler.sv
// Two-stage z = mu + alfa * eps sampler (Q8.8) with element index and end-of-frame tag.
// Build option VAE_SAMPLER_LFSR_EN: eps from internal LFSR instead of the eps_in port.
module vae_reparam_sampler
    import vae_fixed_pkg::*;
#(
    parameter int unsigned       N_ELEM    = 9,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_load,
    vae_reparam_sampler_if.slave  io
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    logic                     en_c;
    logic                     xfer_c;
    logic signed [Q88_W-1:0]  eps_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [Q88_W-1:0]  rnd_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [Q88_W-1:0]  z_c;

    logic [IDX_W-1:0]         cnt;
    logic                     s1_valid;
    logic signed [Q88_W-1:0]  s1_mu;
    logic signed [PROD_W-1:0] s1_prod;
    logic [IDX_W-1:0]         s1_idx;

    assign en_c        = !io.out_valid || io.out_ready;
    assign io.in_ready = en_c;
    assign xfer_c      = io.in_valid && en_c;

`ifdef VAE_SAMPLER_LFSR_EN
    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_lfsr_hi;

    vae_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (seed_load),
        .advance (xfer_c),
        .state   (lfsr_state)
    );

    // Only the low bits form eps, giving a range of [-2, 2).
    assign eps_c          = {{(Q88_W-EPS_BITS){lfsr_state[EPS_BITS-1]}}, lfsr_state[EPS_BITS-1:0]};
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:EPS_BITS];
`else
    logic unused_seed;

    assign eps_c       = io.eps_in;
    assign unused_seed = ^LFSR_SEED;
`endif

    assign prod_c = PROD_W'(io.alfa) * PROD_W'(eps_c);
    assign rnd_c  = sat_q88(round_q88(s1_prod));
    assign sum_c  = SUM_W'(s1_mu) + SUM_W'(rnd_c);
    assign z_c    = sat_q88(PROD_W'(sum_c));

    // Element counter; seed_load restarts the frame after the current element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (seed_load) begin
            cnt <= '0;
        end else if (xfer_c) begin
            cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
    end

    // Stage 1: capture mu, full-precision product and index; data only moves on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mu    <= '0;
            s1_prod  <= '0;
            s1_idx   <= '0;
        end else if (en_c) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) begin
                s1_mu   <= io.mu;
                s1_prod <= prod_c;
                s1_idx  <= cnt;
            end
        end
    end

    // Stage 2: rounded, saturated sum presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.z         <= '0;
            io.out_idx   <= '0;
            io.out_last  <= 1'b0;
        end else if (en_c) begin
            io.out_valid <= s1_valid;
            if (s1_valid) begin
                io.z        <= z_c;
                io.out_idx  <= s1_idx;
                io.out_last <= (s1_idx == LAST_IDX);
            end
        end
    end

endmodule
